// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation-select
// encoding used by the top-level next-state mux and by the testbench.
package usr_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_SHL  = 3'b001;
  localparam mode_t MODE_SHR  = 3'b010;
  localparam mode_t MODE_LOAD = 3'b011;
  localparam mode_t MODE_ROL  = 3'b100;
  localparam mode_t MODE_ROR  = 3'b101;

endpackage

// File: rtl/univ_shift_reg_sat_counter.sv
// Saturating up-counter: synchronous clear beats increment, and the count
// sticks at MAX instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 4,
  parameter int MAX   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_at_max
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == CNT_W'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_at_max = w_at_max;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register (hold/shift/rotate/load, sync clear)
// with a saturating shift counter for serializer/deserializer use.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  mode_t            mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             cnt_done
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;
  logic             w_inc;
  logic             w_load;

  // A 1-bit register has no neighbours: shifts take the serial input and
  // rotates reduce to a no-op on the data.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_shl = sin_r;
      assign w_shr = sin_l;
      assign w_rol = r_q;
      assign w_ror = r_q;
    end else begin : g_wn
      assign w_shl = {r_q[WIDTH-2:0], sin_r};
      assign w_shr = {sin_l, r_q[WIDTH-1:1]};
      assign w_rol = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      assign w_ror = {r_q[0], r_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    w_q_nxt = r_q;
    w_inc   = 1'b0;
    w_load  = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: ;
        MODE_SHL:  begin w_q_nxt = w_shl; w_inc = 1'b1; end
        MODE_SHR:  begin w_q_nxt = w_shr; w_inc = 1'b1; end
        MODE_LOAD: begin w_q_nxt = d;     w_load = 1'b1; end
        MODE_ROL:  begin w_q_nxt = w_rol; w_inc = 1'b1; end
        MODE_ROR:  begin w_q_nxt = w_ror; w_inc = 1'b1; end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= RESET_VAL;
    end else if (clr) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W),
    .MAX   (WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .i_clr    (clr | w_load),
    .i_inc    (w_inc),
    .o_cnt    (shift_cnt),
    .o_at_max (cnt_done)
  );

  assign q        = r_q;
  assign sout_msb = r_q[WIDTH-1];
  assign sout_lsb = r_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus random
// traffic on an 8-bit and a 1-bit instance, against an arithmetic model.
module tb_univ_shift_reg;
  import usr_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       en8 = 1'b0, clr8 = 1'b0, sin_l8 = 1'b0, sin_r8 = 1'b0;
  mode_t      mode8 = MODE_HOLD;
  logic [7:0] d8 = '0, q8;
  logic       msb8, lsb8, done8;
  logic [3:0] cnt8;

  logic       en1 = 1'b0, clr1 = 1'b0, sin_l1 = 1'b0, sin_r1 = 1'b0;
  mode_t      mode1 = MODE_HOLD;
  logic [0:0] d1 = '0, q1;
  logic       msb1, lsb1, done1;
  logic [0:0] cnt1;

  int n_checks = 0;
  int n_errors = 0;
  int m_q8 = 0, m_c8 = 0, m_q1 = 0, m_c1 = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .en(en8), .clr(clr8), .mode(mode8),
    .sin_l(sin_l8), .sin_r(sin_r8), .d(d8), .q(q8), .sout_msb(msb8),
    .sout_lsb(lsb8), .shift_cnt(cnt8), .cnt_done(done8)
  );

  univ_shift_reg #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .en(en1), .clr(clr1), .mode(mode1),
    .sin_l(sin_l1), .sin_r(sin_r1), .d(d1), .q(q1), .sout_msb(msb1),
    .sout_lsb(lsb1), .shift_cnt(cnt1), .cnt_done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: shifts and rotates as plain integer arithmetic on a w-bit value.
  function automatic int ref_q(int w, int q, int m, bit en, bit clr,
                               bit sl, bit sr, int d);
    int mask = (1 << w) - 1;
    if (clr) return 0;
    if (!en) return q;
    case (m)
      1: return ((q << 1) | sr) & mask;
      2: return (q >> 1) | (sl << (w - 1));
      3: return d & mask;
      4: return ((q << 1) | (q >> (w - 1))) & mask;
      5: return (q >> 1) | ((q & 1) << (w - 1));
      default: return q;
    endcase
  endfunction

  function automatic int ref_c(int w, int c, int m, bit en, bit clr);
    if (clr) return 0;
    if (!en) return c;
    if (m == 3) return 0;
    if (m == 1 || m == 2 || m == 4 || m == 5) return (c + 1 > w) ? w : c + 1;
    return c;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "/q8"}, 32'(q8), 32'(m_q8));
    chk({tag, "/cnt8"}, 32'(cnt8), 32'(m_c8));
    chk({tag, "/done8"}, 32'(done8), 32'(m_c8 == 8));
    chk({tag, "/lsb8"}, 32'(lsb8), 32'(m_q8 & 1));
    chk({tag, "/q1"}, 32'(q1), 32'(m_q1));
    chk({tag, "/cnt1"}, 32'(cnt1), 32'(m_c1));
    chk({tag, "/done1"}, 32'(done1), 32'(m_c1 == 1));
    chk({tag, "/msb1"}, 32'(msb1), 32'(m_q1));
  endtask

  // One clock: serial outputs checked before the edge, state after it.
  task automatic cycle(input string tag);
    chk({tag, "/pre_msb8"}, 32'(msb8), 32'((m_q8 >> 7) & 1));
    @(posedge clk);
    m_q8 = ref_q(8, m_q8, int'(mode8), en8, clr8, sin_l8, sin_r8, int'(d8));
    m_c8 = ref_c(8, m_c8, int'(mode8), en8, clr8);
    m_q1 = ref_q(1, m_q1, int'(mode1), en1, clr1, sin_l1, sin_r1, int'(d1));
    m_c1 = ref_c(1, m_c1, int'(mode1), en1, clr1);
    #1;
    check_all(tag);
  endtask

  task automatic set8(input bit e, input bit c, input mode_t m,
                      input bit sl, input bit sr, input logic [7:0] dv);
    en8 = e; clr8 = c; mode8 = m; sin_l8 = sl; sin_r8 = sr; d8 = dv;
  endtask

  task automatic set1(input bit e, input bit c, input mode_t m,
                      input bit sl, input bit sr, input bit dv);
    en1 = e; clr1 = c; mode1 = m; sin_l1 = sl; sin_r1 = sr; d1 = dv;
  endtask

  // Asynchronous reset pulse well away from the clock edge, held across one edge.
  task automatic async_reset(input string tag);
    reset = 1'b0;
    #2;
    m_q8 = 0; m_c8 = 0; m_q1 = 0; m_c1 = 0;
    check_all({tag, "/imm"});
    @(posedge clk);
    #1;
    check_all({tag, "/held"});
    reset = 1'b1;
  endtask

  initial begin
    int sc;
    #12;
    check_all("por");
    reset = 1'b1;
    @(posedge clk); #1;

    // Reset mid-cycle with q = A5.
    set8(1, 0, MODE_LOAD, 0, 0, 8'hA5);
    cycle("ld_a5");
    chk("ld_a5/lit", 32'(q8), 32'hA5);
    set8(1, 0, MODE_HOLD, 0, 0, 8'h00);
    #3;
    async_reset("rst1");
    for (int i = 0; i < 3; i++) cycle("idle");
    chk("idle/lit", 32'(q8), 32'h00);

    // Load then shift left, sin_r=1.
    set8(1, 0, MODE_LOAD, 0, 0, 8'hB4);
    cycle("ld_b4");
    set8(1, 0, MODE_SHL, 0, 1, 8'h00);
    cycle("shl1"); chk("shl1/lit", 32'(q8), 32'h69);
    cycle("shl2"); chk("shl2/lit", 32'(q8), 32'hD3);
    cycle("shl3"); chk("shl3/lit", 32'(q8), 32'hA7);
    chk("shl3/cnt_lit", 32'(cnt8), 32'd3);

    // Serialize to saturation.
    set8(1, 0, MODE_LOAD, 0, 0, 8'h81);
    cycle("ld_81");
    set8(1, 0, MODE_SHR, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cycle("shr_sat");
      if (i == 7) begin
        chk("shr8/q_lit", 32'(q8), 32'h00);
        chk("shr8/done_lit", 32'(done8), 32'd1);
      end
    end
    chk("shr10/cnt_lit", 32'(cnt8), 32'd8);

    // Rotate.
    set8(1, 0, MODE_LOAD, 0, 0, 8'h81);
    cycle("ld_81b");
    set8(1, 0, MODE_ROL, 0, 0, 8'h00);
    cycle("rol"); chk("rol/lit", 32'(q8), 32'h03);
    set8(1, 0, MODE_ROR, 0, 0, 8'h00);
    cycle("ror1"); chk("ror1/lit", 32'(q8), 32'h81);
    cycle("ror2"); chk("ror2/lit", 32'(q8), 32'hC0);
    chk("ror2/cnt_lit", 32'(cnt8), 32'd3);

    // Priority: clr beats en=0 and LOAD; en=0 holds; reserved modes hold.
    set8(1, 0, MODE_LOAD, 0, 0, 8'h5A);
    cycle("ld_5a");
    set8(1, 0, MODE_SHL, 0, 1, 8'h00);
    cycle("pre_clr_shl");
    set8(0, 1, MODE_LOAD, 0, 0, 8'hFF);
    cycle("clr"); chk("clr/lit", 32'(q8), 32'h00);
    set8(1, 0, MODE_LOAD, 0, 0, 8'h3C);
    cycle("ld_3c");
    set8(1, 0, MODE_ROL, 0, 0, 8'h00);
    cycle("rol_3c");
    set8(0, 0, MODE_SHL, 1, 1, 8'h00);
    cycle("en0_shl"); chk("en0/lit", 32'(q8), 32'h78);
    set8(1, 0, mode_t'(3'b110), 1, 1, 8'hFF);
    cycle("rsv110");
    set8(1, 0, mode_t'(3'b111), 1, 1, 8'hFF);
    cycle("rsv111"); chk("rsv/cnt_lit", 32'(cnt8), 32'd1);
    set8(0, 0, MODE_HOLD, 0, 0, 8'h00);

    // WIDTH=1 instance.
    set1(1, 0, MODE_SHL, 0, 1, 0);
    cycle("w1_shl"); chk("w1_shl/lit", 32'(q1), 32'd1);
    set1(1, 0, MODE_ROL, 0, 0, 0);
    cycle("w1_rol"); chk("w1_rol/done_lit", 32'(done1), 32'd1);
    set1(1, 0, MODE_ROR, 0, 0, 0);
    cycle("w1_ror");
    set1(1, 0, MODE_SHR, 0, 1, 1);
    cycle("w1_shr"); chk("w1_shr/lit", 32'(q1), 32'd0);
    set1(1, 0, MODE_LOAD, 0, 0, 0);
    cycle("w1_ld"); chk("w1_ld/cnt_lit", 32'(cnt1), 32'd0);

    // Random traffic on both instances, with occasional mid-cycle resets.
    for (int i = 0; i < 400; i++) begin
      sc = $urandom_range(0, 15);
      set8(sc != 0, $urandom_range(0, 19) == 0, mode_t'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), 8'($urandom));
      set1($urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0,
           mode_t'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
      if (i % 97 == 96) begin
        #3;
        async_reset("rnd_rst");
      end else begin
        cycle("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
